// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Size encodings carried on req_size.
//   - FSM state enum used by load_store_unit.
//   - is_misaligned(): flags accesses whose address is not aligned to the access size.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr,
        StResp
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        unique case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit (little-endian lanes).
// Ports:
//   size      in  2   access size (lsu_pkg SZ_* encoding)
//   sign_ext  in  1   sign-extend sub-word loads
//   lane      in  2   low address bits; byte lane = lane, halfword lane = lane[1]
//   rdata     in  32  word read from memory
//   wdata     in  32  store data, sub-word data right-justified
//   load_data out 32  extracted and extended load result
//   merged    out 32  rdata with the selected lane(s) replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val  = rdata[{lane, 3'b000} +: 8];
        half_val  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        merged    = rdata;
        unique case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_val[15]}}, half_val};
                if (lane[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: begin
                // Word (and the reserved size, which never reaches memory): whole word.
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU execute stage and memory_controller.
// Accepts one request per handshake, issues word-aligned read/write strobes, performs
// read-modify-write for sub-word stores, and returns a one-cycle response.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned halfword/word
// accesses fault; when undefined, low address bits are truncated and only size 3 faults.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in idle)
//   req_write/size/signed    access type, size, sub-word load sign extension
//   req_addr, req_wdata      byte address, right-justified store data
//   rsp_valid/rdata/error    one-cycle response; rdata is 0 for stores and on error
//   mem_read/mem_write       strobes to memory_controller (never both high)
//   mem_addr, mem_wdata      word address and full merged write word
//   mem_rdata, mem_error     controller read data and error
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    localparam logic [1:0] LastCnt = 2'(READ_LATENCY);

    lsu_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [31:0] store_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_fault;
    logic        read_last;
    logic [31:0] load_data;
    logic [31:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_fault = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);
`else
    assign req_fault = (req_size == SZ_RSVD);
`endif

    assign req_ready = (state_q == StIdle) && rst;
    assign accept    = req_valid && req_ready;
    assign read_last = (cnt_q == LastCnt);

    lsu_lane_align u_lane_align (
        .size      (size_q),
        .sign_ext  (signed_q),
        .lane      (lane_q),
        .rdata     (mem_rdata),
        .wdata     (store_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 2'd0;
                if (accept) begin
                    if (req_fault) begin
                        state_d = StResp;
                    end else if (!req_write) begin
                        state_d = StRd;
                    end else if (req_size == SZ_WORD) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd: begin
                if (read_last) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StRmwRd: begin
                if (read_last) begin
                    state_d = mem_error ? StResp : StRmwWr;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StWr, StRmwWr: state_d = StResp;
            StResp:        state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    // Request latches and the address/data registers that drive the memory side.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            lane_q   <= 2'b00;
            store_q  <= 32'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                lane_q   <= req_addr[1:0];
                store_q  <= req_wdata;
                addr_q   <= {req_addr[31:2], 2'b00};
                wdata_q  <= (req_write && req_size == SZ_WORD) ? req_wdata : 32'd0;
                rdata_q  <= 32'd0;
                err_q    <= req_fault;
            end
            if (state_q == StRd && read_last) begin
                rdata_q <= load_data;
                err_q   <= mem_error;
            end
            // Merged word is captured as the read strobe drops, so mem_wdata never
            // changes while a strobe is high.
            if (state_q == StRmwRd && read_last) begin
                wdata_q <= merged;
                err_q   <= mem_error;
            end
            if (state_q == StWr || state_q == StRmwWr) begin
                err_q <= mem_error;
            end
        end
    end

    assign mem_read  = (state_q == StRd) || (state_q == StRmwRd);
    assign mem_write = (state_q == StWr) || (state_q == StRmwWr);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_error = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !write_q) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_error;

    int total = 0;
    int bad   = 0;

    // Per-transaction observations
    int          n_rd;
    int          n_wr;
    int          rsp_cyc;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [31:0] wr_data;
    logic [31:0] strobe_addr;
    logic        both;
    logic        seen;

    load_store_unit #(.READ_LATENCY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_error  (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and record strobes/response for up to 10 cycles.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        step();
        req_valid   = 1'b0;
        n_rd        = 0;
        n_wr        = 0;
        rsp_cyc     = 0;
        got_rdata   = 32'hx;
        got_err     = 1'bx;
        wr_data     = 32'h0;
        strobe_addr = 32'h0;
        both        = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                wr_data = mem_wdata;
            end
            if (mem_read || mem_write) strobe_addr = mem_addr;
            if (mem_read && mem_write) both = 1'b1;
            if (rsp_valid) begin
                rsp_cyc   = c;
                got_rdata = rsp_rdata;
                got_err   = rsp_error;
                break;
            end
            step();
        end
        step();
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_rdata  = 32'd0;
        mem_error  = 1'b0;
        step();
        step();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        step();
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // 1. Word load
        mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'd0);
        chk("t1_nrd", n_rd, 2);
        chk("t1_nwr", n_wr, 0);
        chk("t1_addr", strobe_addr, 32'h0000_0104);
        chk("t1_lat", rsp_cyc, 3);
        chk("t1_rdata", got_rdata, 32'hDEADBEEF);
        chk("t1_err", {31'd0, got_err}, 32'd0);
        chk("t1_ready", {31'd0, req_ready}, 32'd1);

        // 2. Byte loads, lane 3, signed then unsigned
        mem_rdata = 32'h80FF7F01;
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0107, 32'd0);
        chk("t2_sbyte", got_rdata, 32'hFFFFFF80);
        issue(1'b0, 2'd0, 1'b0, 32'h0000_0107, 32'd0);
        chk("t2_ubyte", got_rdata, 32'h00000080);
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0105, 32'd0);
        chk("t2_sbyte_pos", got_rdata, 32'h0000007F);
        // Signed halfword, upper lane
        mem_rdata = 32'h80017FFF;
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0);
        chk("t2_shalf", got_rdata, 32'hFFFF8001);
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'd0);
        chk("t2_shalf_lo", got_rdata, 32'h00007FFF);

        // 3. Halfword store RMW
        mem_rdata = 32'h11223344;
        issue(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000ABCD);
        chk("t3_nrd", n_rd, 2);
        chk("t3_nwr", n_wr, 1);
        chk("t3_addr", strobe_addr, 32'h0000_0200);
        chk("t3_wdata", wr_data, 32'hABCD3344);
        chk("t3_lat", rsp_cyc, 4);
        chk("t3_rdata", got_rdata, 32'd0);
        chk("t3_both", {31'd0, both}, 32'd0);
        // Byte store lane 1
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'hFFFFFF5A);
        chk("t3b_wdata", wr_data, 32'h11225A44);
        chk("t3b_lat", rsp_cyc, 4);
        // Word store
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'h12345678);
        chk("t3c_nrd", n_rd, 0);
        chk("t3c_nwr", n_wr, 1);
        chk("t3c_wdata", wr_data, 32'h12345678);
        chk("t3c_lat", rsp_cyc, 2);
        chk("t3c_err", {31'd0, got_err}, 32'd0);

        // 4. Misaligned word load
        mem_rdata = 32'hCAFEF00D;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("t4_nrd", n_rd, 0);
        chk("t4_lat", rsp_cyc, 1);
        chk("t4_err", {31'd0, got_err}, 32'd1);
        chk("t4_rdata", got_rdata, 32'd0);
`else
        chk("t4_nrd", n_rd, 2);
        chk("t4_addr", strobe_addr, 32'h0000_0100);
        chk("t4_err", {31'd0, got_err}, 32'd0);
        chk("t4_rdata", got_rdata, 32'hCAFEF00D);
`endif

        // Reserved size always faults
        issue(1'b1, 2'd3, 1'b0, 32'h0000_0400, 32'h1);
        chk("rsvd_strobes", n_rd + n_wr, 0);
        chk("rsvd_lat", rsp_cyc, 1);
        chk("rsvd_err", {31'd0, got_err}, 32'd1);

        // 5. Byte store with error on the RMW read
        mem_error = 1'b1;
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0500, 32'h000000AA);
        mem_error = 1'b0;
        chk("t5_nwr", n_wr, 0);
        chk("t5_lat", rsp_cyc, 3);
        chk("t5_err", {31'd0, got_err}, 32'd1);
        chk("t5_rdata", got_rdata, 32'd0);
        chk("t5_ready", {31'd0, req_ready}, 32'd1);

        // Load with error: rdata forced to 0
        mem_error = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'd0);
        mem_error = 1'b0;
        chk("ld_err", {31'd0, got_err}, 32'd1);
        chk("ld_err_rdata", got_rdata, 32'd0);

        // 6. Reset during RD
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_addr   = 32'h0000_0700;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        chk("t6_read_before", {31'd0, mem_read}, 32'd1);
        rst = 1'b0;
        step();
        chk("t6_read_drop", {31'd0, mem_read}, 32'd0);
        chk("t6_ready_in_rst", {31'd0, req_ready}, 32'd0);
        seen = rsp_valid;
        rst  = 1'b1;
        step();
        chk("t6_ready_after", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen = 1'b1;
            step();
        end
        chk("t6_no_rsp", {31'd0, seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and memory_controller, directly upstream of it.
- Accepts one load or store per handshake and drives word-aligned read/write strobes and address/data toward the controller.
- Stores of byte or halfword size use read-modify-write.
- Extracts and sign- or zero-extends load data, then returns a single-cycle response with an error flag.

Parameters:
- READ_LATENCY, 1: clock edges from a mem_read cycle until mem_rdata is valid; legal range 0-3.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- req_signed  in  1  sign-extend a sub-word load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word data right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_error  out  1  access fault.
- mem_read  out  1  read strobe to memory_controller.
- mem_write  out  1  write strobe to memory_controller.
- mem_addr  out  32  {req_addr[31:2],2'b00}.
- mem_wdata  out  32  full merged word.
- mem_rdata  in  32  controller read data.
- mem_error  in  1  controller error.

Behaviour:
- Reset values (when rst=0 at a clock edge): state IDLE; req_ready=0 during reset; all outputs otherwise 0.
- Reset mid-operation: strobes drop at that edge and no response is issued for the in-flight request.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted at an edge where req_valid && req_ready; its fields are latched at that edge.
  - No response backpressure: rsp_valid is high for exactly one cycle, then the unit returns to IDLE.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- Transitions from IDLE on acceptance:
  - Fault (see below) -> RESP.
  - Load -> RD.
  - Word store -> WR.
  - Sub-word store -> RMW_RD.
- RD / RMW_RD:
  - mem_read=1 for READ_LATENCY+1 cycles.
  - mem_rdata and mem_error are sampled at the last of those cycles.
  - RD -> RESP.
  - RMW_RD -> RMW_WR if mem_error=0; otherwise -> RESP with error.
- WR / RMW_WR:
  - mem_write=1 for exactly one cycle; mem_error is sampled in that cycle; -> RESP.
- Latency, in cycles after the acceptance edge, until rsp_valid:
  - Load: READ_LATENCY+2.
  - Word store: 2.
  - Sub-word store: READ_LATENCY+3.
- mem_addr and mem_wdata are held stable while any strobe is high; mem_read and mem_write are never high together.
- Lanes are little-endian:
  - Byte lane = addr[1:0].
  - Halfword lane = addr[1].
  - Merge replaces only the selected lane(s) of the read word with req_wdata[7:0] or [15:0].
- Load extension:
  - Byte: bit 7 is replicated when req_signed=1, else zeros.
  - Halfword: bit 15 likewise.
  - Word loads ignore req_signed.
- Faults (no memory strobe is issued, rsp_error=1 one cycle after acceptance):
  - req_size=3.
  - Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
- rsp_rdata=0 whenever rsp_error=1.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses fault as above.
- Undefined:
  - Low address bits are silently truncated: a halfword uses lane addr[1]; a word uses lane 0.
  - Only req_size=3 faults.

Decomposition:
- Shared package lsu_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - State enum.
  - Function returning the misalignment flag.
- One combinational sub-module, lsu_lane_align:
  - Load path: extract and extend.
  - Store path: lane merge.
- FSM and latches stay in load_store_unit.

Test Plan:
1. Word load addr 0x00000104, mem_rdata=0xDEADBEEF, READ_LATENCY=1 -> mem_read high 2 cycles with mem_addr 0x00000104; rsp_valid 3 cycles after accept; rsp_rdata=0xDEADBEEF; rsp_error=0.
2. Signed byte load addr 0x00000107, mem_rdata=0x80FF7F01 -> rsp_rdata=0xFFFFFF80. Same request with req_signed=0 -> 0x00000080.
3. Halfword store addr 0x00000202, wdata=0x0000ABCD, old word 0x11223344 -> mem_read, then one mem_write with mem_addr=0x00000200, mem_wdata=0xABCD3344; rsp_valid 4 cycles after accept.
4. Word load addr 0x00000101:
   - With LSU_MISALIGN_TRAP_EN: no strobe; rsp_error=1 next cycle.
   - Without it: read of 0x00000100, rsp_error=0.
5. Byte store where mem_error=1 during the RMW read -> mem_write never asserted; rsp_error=1; unit back in IDLE with req_ready=1.
6. rst driven low during RD -> mem_read=0 at that edge; no rsp_valid; req_ready=1 one cycle after rst returns high.
